// File: rtl/fwd_pkg.sv
// Shared encodings for the forwarding / hazard controller.
// Holds the fwd_sel codes, the load-use FSM states and the stall counter width.
package fwd_pkg;

  // Operand source selected by the EX-stage forwarding muxes.
  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,  // register file
    FWD_MEMWB = 2'b01,  // MEM/WB pipeline register
    FWD_EXMEM = 2'b10,  // EX/MEM pipeline register
    FWD_WBRF  = 2'b11   // WB write port (non-write-through register files)
  } fwd_sel_e;

  // Load-use stall sequencer.
  typedef enum logic {
    IDLE    = 1'b0,
    LDSTALL = 1'b1
  } ld_state_e;

  // Wide enough for LOAD_STALL_CYC up to 7.
  localparam int CNT_W = 3;

endpackage

// File: rtl/fwd_scoreboard.sv
// Pending-write scoreboard for multi-cycle (mul/div) results.
// One bit per architectural register; register 0 is never marked pending.
module fwd_scoreboard #(
  parameter int AW = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 set_en,
  input  logic [AW-1:0]        set_addr,
  input  logic                 clr_en,
  input  logic [AW-1:0]        clr_addr,
  output logic [(1<<AW)-1:0]   pending,
  output logic                 busy
);

  logic [(1<<AW)-1:0] pending_d;

  // Next pending vector: clear first, then set, so a same-cycle set wins.
  always_comb begin
    // NOTE: every always_comb output gets a full default first; a path that
    // leaves a variable unassigned would infer a latch.
    pending_d = pending;
    if (clr_en) pending_d[clr_addr] = 1'b0;
    if (set_en && (set_addr != '0)) pending_d[set_addr] = 1'b1;
  end

  // Register the vector and its OR-reduction so busy tracks pending exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: this array lives in flops, not a RAM macro, so an async clear of
      // the whole vector is possible and is needed to drop stale pending bits.
      pending <= '0;
      busy    <= 1'b0;
    end else begin
      pending <= pending_d;
      busy    <= |pending_d;
    end
  end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding-select and hazard-stall controller for a 5-stage pipeline.
// Optional feature: define FWD_WB_BYPASS_EN to add the WB write-port bypass
// (fwd_sel = 2'b11) for register files that are not write-through.
module fwd_hazard_ctrl
  import fwd_pkg::*;
#(
  parameter int REG_AW         = 5,
  parameter int NUM_SRC        = 2,
  parameter int LOAD_STALL_CYC = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_SRC*REG_AW-1:0] id_src,
  input  logic [NUM_SRC-1:0]        id_src_used,
  input  logic [REG_AW-1:0]         ex_rd,
  input  logic                      ex_regwrite,
  input  logic                      ex_memread,
  input  logic [REG_AW-1:0]         mem_rd,
  input  logic                      mem_regwrite,
  input  logic [REG_AW-1:0]         wb_rd,
  input  logic                      wb_regwrite,
  input  logic                      long_issue,
  input  logic [REG_AW-1:0]         long_rd,
  input  logic                      long_done,
  input  logic [REG_AW-1:0]         long_done_rd,
  output logic [NUM_SRC*2-1:0]      fwd_sel,
  output logic                      stall,
  output logic                      sb_busy
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LOAD_STALL_CYC - 1);

  logic [(1<<REG_AW)-1:0] sb_pending;
  logic                   load_use;
  logic                   sb_hit;
  logic [NUM_SRC*2-1:0]   fwd_sel_d;
  logic [REG_AW-1:0]      src;
  fwd_sel_e               sel;
  ld_state_e              state;
  logic [CNT_W-1:0]       cnt;

  fwd_scoreboard #(
    .AW (REG_AW)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_en   (long_issue),
    .set_addr (long_rd),
    .clr_en   (long_done),
    .clr_addr (long_done_rd),
    .pending  (sb_pending),
    .busy     (sb_busy)
  );

`ifndef FWD_WB_BYPASS_EN
  // WB port is unused when the register file writes through.
  logic unused_wb;
  assign unused_wb = ^{wb_rd, wb_regwrite};
`endif

  // Hazard detection: load-use against the EX load, RAW against pending long ops.
  always_comb begin
    load_use = 1'b0;
    sb_hit   = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (id_src_used[k]) begin
        if (ex_memread && (ex_rd != '0) && (ex_rd == id_src[k*REG_AW +: REG_AW]))
          load_use = 1'b1;
        if (sb_pending[id_src[k*REG_AW +: REG_AW]])
          sb_hit = 1'b1;
      end
    end
  end

  assign stall = load_use | (state == LDSTALL) | sb_hit;

  // Per-source forward select, youngest producer first.
  always_comb begin
    fwd_sel_d = '0;
    src       = '0;
    sel       = FWD_RF;
    for (int k = 0; k < NUM_SRC; k++) begin
      src = id_src[k*REG_AW +: REG_AW];
      sel = FWD_RF;
      if (id_src_used[k] && (src != '0)) begin
        if (ex_regwrite && (ex_rd == src))
          sel = FWD_EXMEM;
        else if (mem_regwrite && (mem_rd == src))
          sel = FWD_MEMWB;
`ifdef FWD_WB_BYPASS_EN
        else if (wb_regwrite && (wb_rd == src))
          sel = FWD_WBRF;
`endif
      end
      fwd_sel_d[k*2 +: 2] = sel;
    end
  end

  // Register forward selects for the next EX cycle; a stall loads a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_sel <= '0;
    end else if (stall) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      fwd_sel <= '0;
    end else begin
      fwd_sel <= fwd_sel_d;
    end
  end

  // Load-use sequencer: extends the detection cycle to LOAD_STALL_CYC cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load_use && (LOAD_STALL_CYC > 1)) begin
            state <= LDSTALL;
            cnt   <= CNT_INIT;
          end
        end
        LDSTALL: begin
          cnt <= cnt - 1'b1;
          if (cnt <= CNT_W'(1)) state <= IDLE;
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Self-checking bench for fwd_hazard_ctrl: directed scenarios with literal
// expectations plus randomized traffic checked against a behavioural model.
module tb_fwd_hazard_ctrl;

  localparam int REG_AW  = 5;
  localparam int NUM_SRC = 2;
  localparam int LSC     = 3;
  localparam int NREG    = 1 << REG_AW;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic [NUM_SRC*REG_AW-1:0] id_src;
  logic [NUM_SRC-1:0]        id_src_used;
  logic [REG_AW-1:0]         ex_rd, mem_rd, wb_rd, long_rd, long_done_rd;
  logic                      ex_regwrite, ex_memread, mem_regwrite, wb_regwrite;
  logic                      long_issue, long_done;
  logic [NUM_SRC*2-1:0]      fwd_sel;
  logic                      stall, sb_busy;

  int checks = 0;
  int errors = 0;

  // Behavioural model state.
  bit                   pend [NREG];
  int                   ld_left;
  logic [NUM_SRC*2-1:0] exp_fwd;
  bit                   exp_busy;

  always #5 clk = ~clk;

  fwd_hazard_ctrl #(
    .REG_AW         (REG_AW),
    .NUM_SRC        (NUM_SRC),
    .LOAD_STALL_CYC (LSC)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_src       (id_src),
    .id_src_used  (id_src_used),
    .ex_rd        (ex_rd),
    .ex_regwrite  (ex_regwrite),
    .ex_memread   (ex_memread),
    .mem_rd       (mem_rd),
    .mem_regwrite (mem_regwrite),
    .wb_rd        (wb_rd),
    .wb_regwrite  (wb_regwrite),
    .long_issue   (long_issue),
    .long_rd      (long_rd),
    .long_done    (long_done),
    .long_done_rd (long_done_rd),
    .fwd_sel      (fwd_sel),
    .stall        (stall),
    .sb_busy      (sb_busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [REG_AW-1:0] src_of(input int k);
    return id_src[k*REG_AW +: REG_AW];
  endfunction

  function automatic bit m_load_use();
    for (int k = 0; k < NUM_SRC; k++)
      if (id_src_used[k] && ex_memread && ex_rd != 0 && ex_rd == src_of(k)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_sb_hit();
    for (int k = 0; k < NUM_SRC; k++)
      if (id_src_used[k] && pend[src_of(k)]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [1:0] m_sel(input int k);
    logic [REG_AW-1:0] s;
    s = src_of(k);
    if (!id_src_used[k] || s == 0) return 2'b00;
    if (ex_regwrite && ex_rd == s) return 2'b10;
    if (mem_regwrite && mem_rd == s) return 2'b01;
`ifdef FWD_WB_BYPASS_EN
    if (wb_regwrite && wb_rd == s) return 2'b11;
`endif
    return 2'b00;
  endfunction

  function automatic bit m_stall();
    return m_load_use() || (ld_left > 0) || m_sb_hit();
  endfunction

  task automatic model_reset();
    foreach (pend[i]) pend[i] = 1'b0;
    ld_left  = 0;
    exp_fwd  = '0;
    exp_busy = 1'b0;
  endtask

  // Let combinational outputs settle, then compare everything to the model.
  task automatic settle();
    #1;
    if (!rst_n) model_reset();
    check("stall", stall, m_stall());
    check("fwd_sel", fwd_sel, exp_fwd);
    check("sb_busy", sb_busy, exp_busy);
  endtask

  // Advance the model across the coming rising edge, then move to the next falling edge.
  task automatic tick();
    bit st;
    if (rst_n) begin
      st = m_stall();
      for (int k = 0; k < NUM_SRC; k++) exp_fwd[k*2 +: 2] = st ? 2'b00 : m_sel(k);
      if (ld_left > 0) ld_left--;
      else if (m_load_use()) ld_left = LSC - 1;
      if (long_done) pend[long_done_rd] = 1'b0;
      if (long_issue && long_rd != 0) pend[long_rd] = 1'b1;
      exp_busy = 1'b0;
      foreach (pend[i]) if (pend[i]) exp_busy = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    id_src = '0; id_src_used = '0;
    ex_rd = '0; ex_regwrite = 0; ex_memread = 0;
    mem_rd = '0; mem_regwrite = 0;
    wb_rd = '0; wb_regwrite = 0;
    long_issue = 0; long_rd = '0; long_done = 0; long_done_rd = '0;
  endtask

  task automatic set_src(input int k, input int addr);
    id_src[k*REG_AW +: REG_AW] = REG_AW'(addr);
    id_src_used[k] = 1'b1;
  endtask

  initial begin
    model_reset();
    clear_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    settle();
    check("rst_fwd", fwd_sel, 4'b0000);
    check("rst_busy", sb_busy, 1'b0);
    tick();
    rst_n = 1'b1;

    // EX/MEM beats MEM/WB for the same register.
    clear_inputs();
    ex_rd = 3; ex_regwrite = 1; mem_rd = 3; mem_regwrite = 1; set_src(0, 3);
    settle();
    check("exmem_nostall", stall, 1'b0);
    tick();
    clear_inputs();
    settle();
    check("exmem_src0", fwd_sel[1:0], 2'b10);
    check("exmem_src1", fwd_sel[3:2], 2'b00);
    // MEM/WB match on source 1 only.
    mem_rd = 6; mem_regwrite = 1; ex_rd = 2; ex_regwrite = 1; set_src(1, 6);
    tick();
    clear_inputs();
    settle();
    check("memwb_src1", fwd_sel[3:2], 2'b01);
    check("memwb_src0", fwd_sel[1:0], 2'b00);

    // Load-use: exactly LSC stall cycles with bubbled selects.
    ex_memread = 1; ex_regwrite = 1; ex_rd = 5; set_src(1, 5);
    settle();
    check("ld_stall_c1", stall, 1'b1);
    tick();
    clear_inputs();
    mem_rd = 5; mem_regwrite = 1; set_src(1, 5);
    settle();
    check("ld_stall_c2", stall, 1'b1);
    check("ld_fwd_c2", fwd_sel, 4'b0000);
    tick();
    settle();
    check("ld_stall_c3", stall, 1'b1);
    check("ld_fwd_c3", fwd_sel, 4'b0000);
    tick();
    settle();
    check("ld_stall_c4", stall, 1'b0);
    check("ld_fwd_c4", fwd_sel, 4'b0000);
    tick();
    settle();
    check("ld_fwd_after", fwd_sel[3:2], 2'b01);

    // Multi-cycle write to r7 blocks a reader until the cycle after retirement.
    clear_inputs();
    long_issue = 1; long_rd = 7;
    settle();
    check("lng_busy0", sb_busy, 1'b0);
    tick();
    clear_inputs();
    set_src(0, 7);
    for (int i = 0; i < 3; i++) begin
      settle();
      check("lng_stall", stall, 1'b1);
      check("lng_busy1", sb_busy, 1'b1);
      tick();
    end
    long_done = 1; long_done_rd = 7;
    settle();
    check("lng_stall_done", stall, 1'b1);
    tick();
    long_done = 0;
    settle();
    check("lng_stall_clr", stall, 1'b0);
    check("lng_busy_clr", sb_busy, 1'b0);
    tick();

    // Same-cycle issue and retire of r9: the set wins.
    clear_inputs();
    long_issue = 1; long_rd = 9; long_done = 1; long_done_rd = 9;
    settle();
    tick();
    clear_inputs();
    set_src(0, 9);
    settle();
    check("setwin_stall", stall, 1'b1);
    check("setwin_busy", sb_busy, 1'b1);
    long_done = 1; long_done_rd = 9;
    tick();
    clear_inputs();
    // Register 0 never tracks, stalls or forwards.
    long_issue = 1; long_rd = 0;
    settle();
    tick();
    clear_inputs();
    set_src(0, 0);
    ex_rd = 0; ex_regwrite = 1; ex_memread = 1;
    settle();
    check("r0_stall", stall, 1'b0);
    check("r0_busy", sb_busy, 1'b0);
    tick();
    clear_inputs();
    settle();
    check("r0_fwd", fwd_sel[1:0], 2'b00);

    // Reset in the middle of a load-use stall with a long op pending.
    long_issue = 1; long_rd = 12;
    tick();
    clear_inputs();
    ex_memread = 1; ex_regwrite = 1; ex_rd = 5; set_src(1, 5);
    settle();
    check("rst_mid_stall", stall, 1'b1);
    check("rst_mid_busy", sb_busy, 1'b1);
    tick();
    clear_inputs();
    mem_rd = 5; mem_regwrite = 1; set_src(1, 5);
    settle();
    check("rst_pre_stall", stall, 1'b1);
    rst_n = 1'b0;
    settle();
    check("rst_now_stall", stall, 1'b0);
    check("rst_now_fwd", fwd_sel, 4'b0000);
    check("rst_now_busy", sb_busy, 1'b0);
    tick();
    rst_n = 1'b1;
    settle();
    check("rst_rel_stall", stall, 1'b0);
    tick();
    settle();
    check("rst_no_resid", stall, 1'b0);
    check("rst_rel_fwd", fwd_sel, 4'b0100);
    tick();

    // WB-only match: bypass code only when the WB bypass is built in.
    clear_inputs();
    wb_rd = 4; wb_regwrite = 1; set_src(0, 4);
    settle();
    tick();
    clear_inputs();
    settle();
`ifdef FWD_WB_BYPASS_EN
    check("wb_bypass", fwd_sel[1:0], 2'b11);
`else
    check("wb_bypass", fwd_sel[1:0], 2'b00);
`endif

    // Randomized traffic on a small register window to force frequent matches.
    for (int n = 0; n < 3000; n++) begin
      rst_n        = ($urandom_range(0, 199) != 0);
      for (int k = 0; k < NUM_SRC; k++)
        id_src[k*REG_AW +: REG_AW] = REG_AW'($urandom_range(0, 7));
      id_src_used  = NUM_SRC'($urandom);
      ex_rd        = REG_AW'($urandom_range(0, 7));
      ex_regwrite  = 1'($urandom);
      ex_memread   = ($urandom_range(0, 5) == 0);
      mem_rd       = REG_AW'($urandom_range(0, 7));
      mem_regwrite = 1'($urandom);
      wb_rd        = REG_AW'($urandom_range(0, 7));
      wb_regwrite  = 1'($urandom);
      long_issue   = ($urandom_range(0, 7) == 0);
      long_rd      = REG_AW'($urandom_range(0, 7));
      long_done    = ($urandom_range(0, 2) == 0);
      long_done_rd = REG_AW'($urandom_range(0, 7));
      settle();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_ctrl.md
FWD_HAZARD_CTRL -- requirements
Module: fwd_hazard_ctrl

Interface
REQ-001 SHALL have parameter REG_AW, default 5; register-address width.
REQ-002 SHALL have parameter NUM_SRC, default 2; source operands per instruction.
REQ-003 SHALL have parameter LOAD_STALL_CYC, default 1, range 1..7; load-use stall length in cycles.
REQ-004 SHALL have port clk, input, 1; single clock, all state updates on rising edge.
REQ-005 SHALL have port rst_n, input, 1; asynchronous, active-low reset.
REQ-006 SHALL have port id_src, input, NUM_SRC*REG_AW; ID-stage source addresses, src k at [k*REG_AW +: REG_AW].
REQ-007 SHALL have port id_src_used, input, NUM_SRC; per-source read-enable.
REQ-008 SHALL have port ex_rd / ex_regwrite / ex_memread, input, REG_AW/1/1; ID/EX destination, write enable, load flag.
REQ-009 SHALL have port mem_rd / mem_regwrite, input, REG_AW/1; EX/MEM destination and write enable.
REQ-010 SHALL have port wb_rd / wb_regwrite, input, REG_AW/1; MEM/WB destination and write enable.
REQ-011 SHALL have port long_issue / long_rd, input, 1/REG_AW; multi-cycle (mul/div) op issued from EX.
REQ-012 SHALL have port long_done / long_done_rd, input, 1/REG_AW; multi-cycle op retiring.
REQ-013 SHALL have port fwd_sel, output, NUM_SRC*2; registered forward select per EX-stage source.
REQ-014 SHALL have port stall, output, 1; hold PC and IF/ID, insert bubble into ID/EX.
REQ-015 SHALL have port sb_busy, output, 1; any multi-cycle write pending.

Function
REQ-016 SHALL compute fwd_sel in ID and register it each cycle; it applies to the instruction in EX next cycle.
REQ-017 SHALL encode 2'b10 = from EX/MEM (match ex_rd, ex_regwrite), 2'b01 = from MEM/WB (match mem_rd, mem_regwrite), 2'b00 = register file.
REQ-018 SHALL apply priority 10 > 01 > 11 > 00 per source, evaluated independently per source.
REQ-019 SHALL never forward for an address of 0 or for a source with id_src_used = 0.
REQ-020 SHALL load fwd_sel = 0 (bubble) on any cycle where stall = 1.
REQ-021 SHALL assert stall combinationally in the same cycle when ex_memread = 1, ex_rd != 0 and ex_rd equals any used id_src (load-use).
REQ-022 SHALL load-use FSM states: IDLE, LDSTALL; IDLE->LDSTALL on detection when LOAD_STALL_CYC > 1, with a down-counter loaded with LOAD_STALL_CYC-1.
REQ-023 SHALL in LDSTALL hold stall = 1 and decrement; return to IDLE when counter reaches 1, total stall exactly LOAD_STALL_CYC cycles.
REQ-024 SHALL keep a pending-write scoreboard of 2^REG_AW bits: set bit long_rd on long_issue, clear bit long_done_rd on long_done; address 0 is never set.
REQ-025 SHALL have set win over clear when the same address is issued and retired in the same cycle.
REQ-026 SHALL assert stall while any used id_src has its scoreboard bit set; the scoreboard stall is OR-ed with the load-use stall.
REQ-027 SHALL drive sb_busy = OR of all scoreboard bits, registered.

Reset
REQ-028 SHALL on rst_n low asynchronously clear fwd_sel, the scoreboard, sb_busy, the counter, and FSM = IDLE; stall then depends only on current inputs.
REQ-029 SHALL discard any in-progress load-use stall when reset is asserted mid-stall; no residual stall after release.

Configuration
REQ-030 SHALL with FWD_WB_BYPASS_EN defined add 2'b11 = from WB write port (match wb_rd, wb_regwrite) for non-write-through register files.
REQ-031 SHALL without FWD_WB_BYPASS_EN never produce 2'b11 and ignore wb_rd/wb_regwrite.

Structure
REQ-032 SHALL place fwd_sel encodings (FWD_RF, FWD_MEMWB, FWD_EXMEM, FWD_WBRF) and FSM state constants in shared package fwd_pkg.
REQ-033 SHALL implement the scoreboard as sub-module fwd_scoreboard (set/clear ports, pending vector out).

Verification
REQ-034 SHALL verify: ex_rd=3 ex_regwrite=1, id_src0=3 used -> fwd_sel[1:0]=10 next cycle; mem_rd=3 simultaneously must not override.
REQ-035 SHALL verify: ex_memread=1 ex_rd=5, id_src1=5, LOAD_STALL_CYC=3 -> stall high exactly 3 cycles, fwd_sel=00 during them.
REQ-036 SHALL verify: long_issue rd=7, id_src0=7 used -> stall until cycle after long_done rd=7; sb_busy 1 then 0.
REQ-037 SHALL verify: long_issue rd=9 and long_done rd=9 same cycle -> bit 9 remains set; writes to rd=0 give no stall or forward.
REQ-038 SHALL verify: rst_n low during load-use stall -> stall, fwd_sel, sb_busy 0 immediately; with FWD_WB_BYPASS_EN, wb_rd=4 match only -> 11.
